sop_chain_accumulator: RTL and testbench

Downstream consumer of a 3-deep int_sop_2 DSP chain. It takes the chain's 37-bit signed sum-of-products output and accumulates it over a programmable number of valid taps to form one dot product. The finished result is presented on a valid/ready output port. An internal delay line aligns the operand-issue strobe with the chain's pipeline latency, so the upstream issuer only has to pulse issue_valid alongside the operands it drives into the chain.

---
 rtl/sop_pkg.sv | 44 ++++
 rtl/sop_valid_delay.sv | 30 +++
 rtl/sop_chain_accumulator.sv | 114 +++++++++++
 tb/tb_sop_chain_accumulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared constants, FSM state type and saturating arithmetic for the
// int_sop_2 chain consumer.
package sop_pkg;

    localparam int SOP_RES_W     = 37;
    localparam int SOP_CHAIN_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sop_state_e;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] sum;
    } sat_res_t;

    // Adds two sign-extended operands one bit wider than the 64-bit carrier,
    // then clamps to the signed range of a w-bit result (w <= 63).
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sat_res_t           r;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi) begin
            r.sat = 1'b1;
            r.sum = hi[63:0];
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.sum = lo[63:0];
        end else begin
            r.sat = 1'b0;
            r.sum = s[63:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sop_valid_delay.sv
// Fixed-depth valid shift register that lines the issue strobe up with the
// chain result; it never stalls.
module sop_valid_delay #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] shift_reg;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) shift_reg <= '0;
                else        shift_reg <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) shift_reg <= '0;
                else        shift_reg <= {shift_reg[LAT-2:0], din};
            end
        end
    endgenerate

    assign dout = shift_reg[LAT-1];

endmodule

// File: rtl/sop_chain_accumulator.sv
// Accumulates signed chain results over a programmed number of taps and
// presents the saturated dot product on a valid/ready port.
module sop_chain_accumulator
    import sop_pkg::*;
#(
    parameter int IN_W      = SOP_RES_W,
    parameter int ACC_W     = 48,
    parameter int LEN_W     = 10,
    parameter int CHAIN_LAT = SOP_CHAIN_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic                    issue_valid,
    input  logic signed [IN_W-1:0]  chain_result,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    drop_err
);

    sop_state_e              state_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] out_data_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [LEN_W-1:0]        count_reg;
    logic                    sat_reg;
    logic                    out_sat_reg;
    logic                    drop_err_reg;
    logic                    tap_valid;
    logic                    last_tap;
    sat_res_t                add_res;
    logic signed [ACC_W-1:0] sum_next;
    logic                    sat_next;
    logic                    unused_sum_hi;

    sop_valid_delay #(
        .LAT (CHAIN_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .din   (issue_valid),
        .dout  (tap_valid)
    );

    always_comb begin
        add_res = sat_add(64'(acc_reg), 64'(chain_result), ACC_W);
    end

    assign sum_next      = add_res.sum[ACC_W-1:0];
    assign sat_next      = sat_reg | add_res.sat;
    assign unused_sum_hi = ^add_res.sum[63:ACC_W];
    assign last_tap      = (count_reg == len_reg - LEN_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            out_data_reg <= '0;
            len_reg      <= '0;
            count_reg    <= '0;
            sat_reg      <= 1'b0;
            out_sat_reg  <= 1'b0;
            drop_err_reg <= 1'b0;
        end else begin
            // A tap outside ACCUM has no vector to join; it is flagged and lost.
            if (tap_valid && state_reg != ACCUM) drop_err_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg   <= vec_len;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        sat_reg   <= 1'b0;
                        if (vec_len == '0) begin
                            out_data_reg <= '0;
                            out_sat_reg  <= 1'b0;
                            state_reg    <= HOLD;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (tap_valid) begin
                        acc_reg   <= sum_next;
                        sat_reg   <= sat_next;
                        count_reg <= count_reg + LEN_W'(1);
                        if (last_tap) begin
                            out_data_reg <= sum_next;
                            out_sat_reg  <= sat_next;
                            state_reg    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == HOLD);
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign drop_err  = drop_err_reg;

endmodule

// File: tb/tb_sop_chain_accumulator.sv
// Directed bench for sop_chain_accumulator with a cycle-level reference model
// and a simple chain stand-in that returns issued data CHAIN_LAT cycles later.
module tb_sop_chain_accumulator;

    localparam int IN_W  = 37;
    localparam int ACC_W = 48;
    // Vectors longer than 2048 taps are needed to reach the 48-bit rails.
    localparam int LEN_W = 12;
    localparam int LAT   = 3;

    localparam longint MAXV = 64'sd140737488355327;
    localparam longint MINV = -64'sd140737488355328;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        vec_len = '0;
    logic                    issue_valid = 1'b0;
    logic signed [IN_W-1:0]  issue_data = '0;
    logic signed [IN_W-1:0]  chain_result = '0;
    logic                    out_ready = 1'b0;
    logic                    busy;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sat;
    logic                    drop_err;

    int errors = 0;
    int checks = 0;

    sop_chain_accumulator #(
        .IN_W      (IN_W),
        .ACC_W     (ACC_W),
        .LEN_W     (LEN_W),
        .CHAIN_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vec_len      (vec_len),
        .issue_valid  (issue_valid),
        .chain_result (chain_result),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Chain stand-in: operands presented in one cycle appear on chain_result LAT cycles later.
    logic signed [IN_W-1:0] cdata [LAT] = '{default: '0};
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) cdata[i] = cdata[i-1];
        cdata[0] = issue_data;
        #1 chain_result = cdata[LAT-1];
    end

    // Reference model: vector-level rules evaluated once per clock.
    longint     m_acc = 0;
    longint     m_out_data = 0;
    int         m_mode = 0;   // 0 idle, 1 collecting taps, 2 result offered
    int         m_cnt = 0;
    int         m_len = 0;
    bit         m_sat = 1'b0;
    bit         m_out_sat = 1'b0;
    bit         m_drop = 1'b0;
    bit [LAT-1:0] m_pipe = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc = 0; m_out_data = 0; m_mode = 0; m_cnt = 0; m_len = 0;
            m_sat = 1'b0; m_out_sat = 1'b0; m_drop = 1'b0; m_pipe = '0;
        end else begin
            bit     tap;
            longint s;
            tap = m_pipe[LAT-1];
            if (tap && m_mode != 1) m_drop = 1'b1;
            if (m_mode == 0) begin
                if (start) begin
                    m_len = int'(vec_len); m_acc = 0; m_cnt = 0; m_sat = 1'b0;
                    if (m_len == 0) begin
                        m_mode = 2; m_out_data = 0; m_out_sat = 1'b0;
                    end else begin
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (tap) begin
                    s = m_acc + longint'(chain_result);
                    if (s > MAXV) begin s = MAXV; m_sat = 1'b1; end
                    if (s < MINV) begin s = MINV; m_sat = 1'b1; end
                    m_acc = s;
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_mode = 2; m_out_data = s; m_out_sat = m_sat;
                    end
                end
            end else begin
                if (out_ready) m_mode = 0;
            end
            m_pipe = {m_pipe[LAT-2:0], issue_valid};
        end
    end

    always @(negedge clk) begin
        check("busy",      64'(busy),      64'(m_mode != 0));
        check("out_valid", 64'(out_valid), 64'(m_mode == 2));
        check("out_data",  64'(out_data),  m_out_data);
        check("out_sat",   64'(out_sat),   64'(m_out_sat));
        check("drop_err",  64'(drop_err),  64'(m_drop));
        if (out_valid && out_ready)
            $display("txn: out_data=%0d out_sat=%0b", out_data, out_sat);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input int len);
        start = 1'b1;
        vec_len = LEN_W'(len);
        step();
        start = 1'b0;
        vec_len = '0;
    endtask

    task automatic issue(input logic signed [IN_W-1:0] v);
        issue_valid = 1'b1;
        issue_data = v;
        step();
        issue_valid = 1'b0;
        issue_data = '0;
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check("wait_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        reset = 1'b1;
        step();

        // 1: four taps, result one cycle after the last tap
        start_vec(4);
        issue(37'sd10); issue(-37'sd3); issue(37'sd7); issue(37'sd100);
        step(); step();
        check("t1_not_early", 64'(out_valid), 64'd0);
        step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data",  64'(out_data),  64'd114);
        check("t1_sat",   64'(out_sat),   64'd0);

        // 2: back-pressure keeps the result stable
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", 64'(out_valid), 64'd1);
            check("t2_hold_data",  64'(out_data),  64'd114);
        end
        handshake();
        check("t2_valid_drop", 64'(out_valid), 64'd0);
        check("t2_busy_drop",  64'(busy),      64'd0);

        // 3: saturation at both rails
        start_vec(2100);
        for (int i = 0; i < 2100; i++) issue(37'sh0F_FFFF_FFFF);
        wait_valid(10);
        check("t3_pos_data", 64'(out_data), 64'h00007FFF_FFFFFFFF);
        check("t3_pos_sat",  64'(out_sat),  64'd1);
        handshake();
        start_vec(2100);
        for (int i = 0; i < 2100; i++) issue(37'sh10_0000_0000);
        wait_valid(10);
        check("t3_neg_data", 64'(out_data), 64'hFFFF8000_00000000);
        check("t3_neg_sat",  64'(out_sat),  64'd1);
        handshake();

        // 4: zero-length vector, and start colliding with the handshake
        start_vec(0);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_data",  64'(out_data),  64'd0);
        check("t4_sat",   64'(out_sat),   64'd0);
        start = 1'b1;
        vec_len = LEN_W'(3);
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        check("t4_start_ignored", 64'(busy), 64'd0);

        // 5: stray tap while idle
        issue(37'sd55);
        step(); step();
        check("t5_drop_early", 64'(drop_err), 64'd0);
        step();
        check("t5_drop_set", 64'(drop_err), 64'd1);
        start_vec(2);
        issue(37'sd5); issue(37'sd6);
        wait_valid(10);
        check("t5_data", 64'(out_data), 64'd11);
        handshake();

        // 6: reset in the middle of a vector
        start_vec(4);
        issue(37'sd1); issue(37'sd2); issue(37'sd3); issue(37'sd4);
        step();
        reset = 1'b0;
        #1;
        check("t6_rst_busy",  64'(busy),     64'd0);
        check("t6_rst_drop",  64'(drop_err), 64'd0);
        check("t6_rst_data",  64'(out_data), 64'd0);
        repeat (2) step();
        reset = 1'b1;
        step();
        start_vec(2);
        issue(37'sd1); issue(37'sd2);
        wait_valid(10);
        check("t6_data", 64'(out_data), 64'd3);
        check("t6_drop", 64'(drop_err), 64'd0);
        handshake();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
